// File: rtl/bctrl_pkg.sv
// Shared types and constants for the branch resolve unit and its predictor table.
// The saturating 2-bit counter step lives here so the table and any checker agree.
package bctrl_pkg;

  localparam logic [2:0] OP_CJMP = 3'b101;

  typedef enum logic [1:0] {
    C_Z  = 2'b00,
    C_NZ = 2'b01,
    C_C  = 2'b10,
    C_NC = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_TGT   = 2'b01,
    PC_RECOV = 2'b10
  } pcmux_e;

  typedef logic [1:0] ctr2_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam ctr2_t CTR_INIT = 2'b01;

  function automatic ctr2_t ctr_next(input ctr2_t cur, input logic up);
    ctr2_t nxt;
    if (up) begin
      nxt = (cur == 2'b11) ? cur : cur + 2'b01;
    end else begin
      nxt = (cur == 2'b00) ? cur : cur - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_table.sv
// 2-bit saturating direction predictor: one async read port, one update port.
// A same-cycle read of the index being updated sees the pre-update value.
module bpred_table
  import bctrl_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  ctr2_t tbl_r [DEPTH];

  // Counter array: weakly not-taken after reset, frozen when prediction is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_r[i] <= CTR_INIT;
      end
    end else if (wr_en && (PREDICT_EN != 1'b0)) begin
      tbl_r[wr_idx] <= ctr_next(tbl_r[wr_idx], wr_taken);
    end
  end

  assign rd_taken = (PREDICT_EN != 1'b0) ? tbl_r[rd_idx][1] : 1'b0;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional jumps on Z/C, drives the fetch PC mux, predicts direction and
// holds flush for FLUSH_CYCLES cycles after each mispredict.
module branch_resolve_unit
  import bctrl_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter bit PREDICT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] fetch_pc_idx,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [4:0]       res_command,
  input  logic [IDX_W-1:0] res_pc_idx,
  input  logic             res_pred_taken,
  input  logic             Zff,
  input  logic             Cff,
  output logic [1:0]       PCmux,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_ZERO  = FC_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic            is_branch_s;
  logic            taken_s;
  logic            resolve_s;
  logic            mispredict_s;
  pcmux_e          pcmux_s;
  state_e          state_r, state_s;
  logic [FC_W-1:0] fcnt_r, fcnt_s;
  logic            flush_r, flush_s;
  logic [CNT_W-1:0] cnt_r;

  assign is_branch_s  = (res_command[4:2] == OP_CJMP);
  assign resolve_s    = res_valid && is_branch_s && (state_r == IDLE);
  assign mispredict_s = resolve_s && (taken_s != res_pred_taken);

  // Branch condition decode from the low opcode bits.
  always_comb begin
    taken_s = 1'b0;
    case (cond_e'(res_command[1:0]))
      C_Z:     taken_s = Zff;
      C_NZ:    taken_s = !Zff;
      C_C:     taken_s = Cff;
      C_NC:    taken_s = !Cff;
      default: taken_s = 1'b0;
    endcase
  end

  // PC mux select; forced to PC+1 while reset is asserted.
  always_comb begin
    pcmux_s = PC_INC;
    if (rst_n && mispredict_s) begin
      pcmux_s = taken_s ? PC_TGT : PC_RECOV;
    end else begin
      pcmux_s = PC_INC;
    end
  end

  // Flush FSM next state: a mispredict loads the down-counter, zero count exits.
  always_comb begin
    state_s = state_r;
    fcnt_s  = fcnt_r;
    flush_s = flush_r;
    case (state_r)
      IDLE: begin
        if (mispredict_s) begin
          state_s = FLUSH;
          fcnt_s  = FC_LOAD;
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      FLUSH: begin
        if (fcnt_r == FC_ZERO) begin
          state_s = IDLE;
          flush_s = 1'b0;
        end else begin
          fcnt_s  = fcnt_r - FC_ONE;
          flush_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        fcnt_s  = FC_ZERO;
        flush_s = 1'b0;
      end
    endcase
  end

  // Flush FSM state, down-counter and registered flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      fcnt_r  <= FC_ZERO;
      flush_r <= 1'b0;
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
      flush_r <= flush_s;
    end
  end

  // Saturating mispredict statistics counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (mispredict_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  bpred_table #(
    .IDX_W      (IDX_W),
    .PREDICT_EN (PREDICT_EN)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fetch_pc_idx),
    .rd_taken (pred_taken),
    .wr_en    (resolve_s),
    .wr_idx   (res_pc_idx),
    .wr_taken (taken_s)
  );

  assign PCmux          = pcmux_s;
  assign flush          = flush_r;
  assign stall          = flush_r;
  assign mispredict_cnt = cnt_r;

endmodule
